// File: rtl/note_config_bank.sv
`default_nettype none
// ============================================================================
//  Module   : note_config_bank
//  Purpose  : AXI4-Lite register bank of per-voice note configuration, with
//             shadow registers committed atomically on the audio sample tick.
//  Revision : 1.0
// ============================================================================
module note_config_bank #(
    parameter int NUM_VOICES = 8,
    parameter int FREQ_W     = 24,
    parameter int VEL_W      = 7,
    parameter int ADDR_W     = 8
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic [ADDR_W-1:0]            S_AXI_AWADDR,
    input  logic                         S_AXI_AWVALID,
    output logic                         S_AXI_AWREADY,
    input  logic [31:0]                  S_AXI_WDATA,
    input  logic [3:0]                   S_AXI_WSTRB,
    input  logic                         S_AXI_WVALID,
    output logic                         S_AXI_WREADY,
    output logic [1:0]                   S_AXI_BRESP,
    output logic                         S_AXI_BVALID,
    input  logic                         S_AXI_BREADY,
    input  logic [ADDR_W-1:0]            S_AXI_ARADDR,
    input  logic                         S_AXI_ARVALID,
    output logic                         S_AXI_ARREADY,
    output logic [31:0]                  S_AXI_RDATA,
    output logic [1:0]                   S_AXI_RRESP,
    output logic                         S_AXI_RVALID,
    input  logic                         S_AXI_RREADY,
    input  logic                         sample_tick,
    output logic [NUM_VOICES*FREQ_W-1:0] freq_o,
    output logic [NUM_VOICES-1:0]        gate_o,
    output logic [NUM_VOICES*VEL_W-1:0]  vel_o,
    output logic                         update_o
);

    localparam logic [31:0] c_NUM_WORDS = 32'(4 + 2 * NUM_VOICES);
    localparam logic [31:0] c_INFO      = {8'h01, 8'(VEL_W), 8'(FREQ_W), 8'(NUM_VOICES)};
    localparam logic [1:0]  c_OKAY      = 2'b00;
    localparam logic [1:0]  c_SLVERR    = 2'b10;

    logic                         r_awready, r_bvalid, r_arready, r_rvalid;
    logic [1:0]                   r_bresp, r_rresp;
    logic [31:0]                  r_rdata;
    logic                         r_auto, r_pending, r_update;
    logic [FREQ_W-1:0]            r_sh_freq [NUM_VOICES];
    logic                         r_sh_gate [NUM_VOICES];
    logic [VEL_W-1:0]             r_sh_vel  [NUM_VOICES];
    logic [NUM_VOICES*FREQ_W-1:0] r_act_freq;
    logic [NUM_VOICES-1:0]        r_act_gate;
    logic [NUM_VOICES*VEL_W-1:0]  r_act_vel;

    logic [31:0] w_aw_idx, w_aw_off, w_ar_idx, w_ar_off;
    logic        w_aw_ok, w_aw_voice, w_ar_ok, w_ar_voice;
    logic        w_wr_fire, w_rd_fire, w_commit_set, w_copy;
    logic [31:0] w_rd_word, w_wr_old, w_wr_merged;
    logic        w_unused;

    function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

    assign w_aw_idx   = 32'(S_AXI_AWADDR[ADDR_W-1:2]);
    assign w_aw_off   = w_aw_idx - 32'd4;
    assign w_aw_ok    = w_aw_idx < c_NUM_WORDS;
    assign w_aw_voice = w_aw_ok && (w_aw_idx >= 32'd4);
    assign w_ar_idx   = 32'(S_AXI_ARADDR[ADDR_W-1:2]);
    assign w_ar_off   = w_ar_idx - 32'd4;
    assign w_ar_ok    = w_ar_idx < c_NUM_WORDS;
    assign w_ar_voice = w_ar_ok && (w_ar_idx >= 32'd4);

    // Ready is registered, so the handshake completes on the edge where it is high.
    assign w_wr_fire = r_awready && S_AXI_AWVALID && S_AXI_WVALID;
    assign w_rd_fire = r_arready && S_AXI_ARVALID;
    assign w_copy    = sample_tick && r_pending;

    always_comb begin
        w_rd_word = '0;
        w_wr_old  = '0;
        case (w_ar_idx)
            32'd0:   w_rd_word = {30'd0, r_auto, 1'b0};
            32'd1:   w_rd_word = {31'd0, r_pending};
            32'd2:   w_rd_word = c_INFO;
            default: w_rd_word = '0;
        endcase
        if (w_aw_idx == 32'd0) begin
            w_wr_old = {30'd0, r_auto, 1'b0};
        end
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (w_ar_voice && w_ar_off[31:1] == 31'(v)) begin
                w_rd_word = w_ar_off[0] ? 32'({r_sh_vel[v], r_sh_gate[v]}) : 32'(r_sh_freq[v]);
            end
            if (w_aw_voice && w_aw_off[31:1] == 31'(v)) begin
                w_wr_old = w_aw_off[0] ? 32'({r_sh_vel[v], r_sh_gate[v]}) : 32'(r_sh_freq[v]);
            end
        end
    end

    assign w_wr_merged  = f_merge(w_wr_old, S_AXI_WDATA, S_AXI_WSTRB);
    assign w_commit_set = w_wr_fire &&
                          (((w_aw_idx == 32'd0) && S_AXI_WSTRB[0] && S_AXI_WDATA[0]) ||
                           (w_aw_voice && r_auto));
    assign w_unused     = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], w_wr_merged};

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_awready  <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= c_OKAY;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rresp    <= c_OKAY;
            r_rdata    <= '0;
            r_auto     <= 1'b0;
            r_pending  <= 1'b0;
            r_update   <= 1'b0;
            r_act_freq <= '0;
            r_act_gate <= '0;
            r_act_vel  <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_sh_freq[v] <= '0;
                r_sh_gate[v] <= 1'b0;
                r_sh_vel[v]  <= '0;
            end
        end else begin
            r_awready <= !r_awready && S_AXI_AWVALID && S_AXI_WVALID && !r_bvalid;
            if (w_wr_fire) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_aw_ok ? c_OKAY : c_SLVERR;
            end else if (r_bvalid && S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end

            r_arready <= !r_arready && S_AXI_ARVALID && !r_rvalid;
            if (w_rd_fire) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_word;
                r_rresp  <= w_ar_ok ? c_OKAY : c_SLVERR;
            end else if (r_rvalid && S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end

            if (w_wr_fire && w_aw_idx == 32'd0) begin
                r_auto <= w_wr_merged[1];
            end
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (w_wr_fire && w_aw_voice && w_aw_off[31:1] == 31'(v)) begin
                    if (w_aw_off[0]) begin
                        r_sh_gate[v] <= w_wr_merged[0];
                        r_sh_vel[v]  <= w_wr_merged[VEL_W:1];
                    end else begin
                        r_sh_freq[v] <= w_wr_merged[FREQ_W-1:0];
                    end
                end
            end

            // Copy reads the shadows before any same-cycle write lands.
            if (w_copy) begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    r_act_freq[v*FREQ_W +: FREQ_W] <= r_sh_freq[v];
                    r_act_gate[v]                  <= r_sh_gate[v];
                    r_act_vel[v*VEL_W +: VEL_W]    <= r_sh_vel[v];
                end
            end
            r_update <= w_copy;

            // A new commit request outranks the clear from a simultaneous copy.
            if (w_commit_set) begin
                r_pending <= 1'b1;
            end else if (w_copy) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_awready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RDATA   = r_rdata;
    assign freq_o        = r_act_freq;
    assign gate_o        = r_act_gate;
    assign vel_o         = r_act_vel;
    assign update_o      = r_update;

endmodule
`default_nettype wire

// File: tb/tb_note_config_bank.sv
`default_nettype none
// Self-checking bench for note_config_bank with default parameters:
// table-driven register accesses plus hand-built commit/backpressure/reset sequences.
module tb_note_config_bank;

    logic         ACLK, ARESET;
    logic [7:0]   S_AXI_AWADDR, S_AXI_ARADDR;
    logic         S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
    logic [31:0]  S_AXI_WDATA, S_AXI_RDATA;
    logic [3:0]   S_AXI_WSTRB;
    logic [1:0]   S_AXI_BRESP, S_AXI_RRESP;
    logic         S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic         S_AXI_RVALID, S_AXI_RREADY, sample_tick, update_o;
    logic [191:0] freq_o;
    logic [7:0]   gate_o;
    logic [55:0]  vel_o;

    note_config_bank dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY), .sample_tick(sample_tick),
        .freq_o(freq_o), .gate_o(gate_o), .vel_o(vel_o), .update_o(update_o)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;
    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
    } rd_exp_t;

    localparam int NVEC = 18;
    vec_t         vecs [NVEC];
    rd_exp_t      q_rd [$];
    logic [1:0]   q_wr [$];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic         upd_at_hs;
    logic [191:0] freq_at_hs;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] er, input bit tick_hs);
        int n;
        logic [1:0] e;
        q_wr.push_back(er);
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        n = 0;
        while (!S_AXI_AWREADY && n < 50) begin @(posedge ACLK); #1; n++; end
        if (!S_AXI_AWREADY) begin
            timeout("awready");
            S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
            void'(q_wr.pop_front());
            return;
        end
        sample_tick = tick_hs;
        @(posedge ACLK); #1;
        sample_tick = 1'b0;
        upd_at_hs  = update_o;
        freq_at_hs = freq_o;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        n = 0;
        while (!S_AXI_BVALID && n < 50) begin @(posedge ACLK); #1; n++; end
        e = q_wr.pop_front();
        if (!S_AXI_BVALID) begin timeout("bvalid"); return; end
        check($sformatf("bresp@%0h", a), S_AXI_BRESP, e);
        @(posedge ACLK); #1;
    endtask

    task automatic do_read(input logic [7:0] a, input logic [31:0] ed, input logic [1:0] er);
        int n;
        rd_exp_t e;
        q_rd.push_back('{er, ed});
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
        n = 0;
        while (!S_AXI_ARREADY && n < 50) begin @(posedge ACLK); #1; n++; end
        if (!S_AXI_ARREADY) begin
            timeout("arready");
            S_AXI_ARVALID = 1'b0;
            void'(q_rd.pop_front());
            return;
        end
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        n = 0;
        while (!S_AXI_RVALID && n < 50) begin @(posedge ACLK); #1; n++; end
        e = q_rd.pop_front();
        if (!S_AXI_RVALID) begin timeout("rvalid"); return; end
        check($sformatf("rdata@%0h", a), S_AXI_RDATA, e.data);
        check($sformatf("rresp@%0h", a), S_AXI_RRESP, e.resp);
        @(posedge ACLK); #1;
    endtask

    task automatic pulse_tick();
        sample_tick = 1'b1;
        @(posedge ACLK); #1;
        sample_tick = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0]  = '{1'b0, 8'h08, 32'h0, 4'h0, 2'b00, 32'h01071808};
        vecs[1]  = '{1'b0, 8'h04, 32'h0, 4'h0, 2'b00, 32'h0};
        vecs[2]  = '{1'b0, 8'h00, 32'h0, 4'h0, 2'b00, 32'h0};
        vecs[3]  = '{1'b1, 8'h10, 32'h00ABCDEF, 4'hF, 2'b00, 32'h0};
        vecs[4]  = '{1'b1, 8'h14, 32'h0000000B, 4'hF, 2'b00, 32'h0};
        vecs[5]  = '{1'b0, 8'h10, 32'h0, 4'h0, 2'b00, 32'h00ABCDEF};
        vecs[6]  = '{1'b0, 8'h14, 32'h0, 4'h0, 2'b00, 32'h0000000B};
        vecs[7]  = '{1'b1, 8'h18, 32'h12345678, 4'b0010, 2'b00, 32'h0};
        vecs[8]  = '{1'b0, 8'h18, 32'h0, 4'h0, 2'b00, 32'h00005600};
        vecs[9]  = '{1'b1, 8'h50, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0};
        vecs[10] = '{1'b0, 8'h50, 32'h0, 4'h0, 2'b10, 32'h0};
        vecs[11] = '{1'b0, 8'h04, 32'h0, 4'h0, 2'b00, 32'h0};
        vecs[12] = '{1'b1, 8'h0C, 32'hFFFFFFFF, 4'hF, 2'b00, 32'h0};
        vecs[13] = '{1'b0, 8'h0C, 32'h0, 4'h0, 2'b00, 32'h0};
        vecs[14] = '{1'b1, 8'h1C, 32'hFFFFFFFF, 4'hF, 2'b00, 32'h0};
        vecs[15] = '{1'b0, 8'h1C, 32'h0, 4'h0, 2'b00, 32'h000000FF};
        vecs[16] = '{1'b1, 8'h20, 32'hFFFFFFFF, 4'hF, 2'b00, 32'h0};
        vecs[17] = '{1'b0, 8'h20, 32'h0, 4'h0, 2'b00, 32'h00FFFFFF};

        ARESET = 1'b1; sample_tick = 1'b0;
        S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
        S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1; S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b1; upd_at_hs = 1'b0; freq_at_hs = '0;
        repeat (3) @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        check("rst_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 0);
        check("rst_valid", {S_AXI_BVALID, S_AXI_RVALID}, 0);
        check("rst_resp_data", {S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}, 0);
        check("rst_outputs", {freq_o, gate_o, vel_o[55:0], update_o}, 0);

        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp, 1'b0);
            else            do_read(vecs[i].addr, vecs[i].rdata, vecs[i].resp);
        end
        check("oor_no_change", {freq_o, gate_o, vel_o}, 0);

        // Explicit commit, applied on the next tick
        do_write(8'h00, 32'h1, 4'hF, 2'b00, 1'b0);
        do_read(8'h04, 32'h1, 2'b00);
        check("pre_tick_freq", freq_o, 0);
        check("pre_tick_update", update_o, 0);
        pulse_tick();
        check("commit_update", update_o, 1);
        check("commit_freq0", freq_o[23:0], 24'hABCDEF);
        check("commit_gate0", gate_o[0], 1);
        check("commit_vel0", vel_o[6:0], 7'd5);
        @(posedge ACLK); #1;
        check("update_once", update_o, 0);
        do_read(8'h04, 32'h0, 2'b00);

        // Tick with nothing pending
        pulse_tick();
        check("idle_tick_update", update_o, 0);
        check("idle_tick_freq0", freq_o[23:0], 24'hABCDEF);

        // Auto-commit; voice write coinciding with a tick
        do_write(8'h00, 32'h2, 4'hF, 2'b00, 1'b0);
        do_read(8'h00, 32'h2, 2'b00);
        do_write(8'h48, 32'h1, 4'hF, 2'b00, 1'b1);
        check("coincide_no_update", upd_at_hs, 0);
        do_read(8'h04, 32'h1, 2'b00);
        check("coincide_freq7_old", freq_o[191:168], 0);
        pulse_tick();
        check("auto_update", update_o, 1);
        check("auto_freq7", freq_o[191:168], 24'h000001);
        do_write(8'h48, 32'h2, 4'hF, 2'b00, 1'b0);
        do_write(8'h48, 32'h3, 4'hF, 2'b00, 1'b1);
        check("copy_vs_write_update", upd_at_hs, 1);
        check("copy_vs_write_freq7", freq_at_hs[191:168], 24'h000002);
        do_read(8'h04, 32'h1, 2'b00);
        pulse_tick();
        check("copy_vs_write_next", freq_o[191:168], 24'h000003);

        // Write response backpressure
        S_AXI_BREADY = 1'b0;
        S_AXI_AWADDR = 8'h40; S_AXI_WDATA = 32'h111; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        n = 0;
        while (!S_AXI_AWREADY && n < 50) begin @(posedge ACLK); #1; n++; end
        if (!S_AXI_AWREADY) timeout("bp_awready1");
        @(posedge ACLK); #1;
        S_AXI_AWADDR = 8'h44; S_AXI_WDATA = 32'h3;
        for (int k = 0; k < 5; k++) begin
            check("bp_bvalid_hold", {S_AXI_BVALID, S_AXI_BRESP}, 3'b100);
            check("bp_awready_low", {S_AXI_AWREADY, S_AXI_WREADY}, 0);
            @(posedge ACLK); #1;
        end
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        check("bp_bvalid_done", S_AXI_BVALID, 0);
        n = 0;
        while (!S_AXI_AWREADY && n < 50) begin @(posedge ACLK); #1; n++; end
        if (!S_AXI_AWREADY) timeout("bp_awready2");
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        check("bp_second_bvalid", S_AXI_BVALID, 1);
        @(posedge ACLK); #1;

        // Read data backpressure
        S_AXI_RREADY = 1'b0;
        S_AXI_ARADDR = 8'h40; S_AXI_ARVALID = 1'b1;
        n = 0;
        while (!S_AXI_ARREADY && n < 50) begin @(posedge ACLK); #1; n++; end
        if (!S_AXI_ARREADY) timeout("bp_arready1");
        @(posedge ACLK); #1;
        S_AXI_ARADDR = 8'h44;
        for (int k = 0; k < 5; k++) begin
            check("bp_rvalid_hold", {S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA}, {1'b1, 2'b00, 32'h111});
            check("bp_arready_low", S_AXI_ARREADY, 0);
            @(posedge ACLK); #1;
        end
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        check("bp_rvalid_done", S_AXI_RVALID, 0);
        n = 0;
        while (!S_AXI_ARREADY && n < 50) begin @(posedge ACLK); #1; n++; end
        if (!S_AXI_ARREADY) timeout("bp_arready2");
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        check("bp_second_rdata", {S_AXI_RVALID, S_AXI_RDATA}, {1'b1, 32'h3});
        @(posedge ACLK); #1;

        // Reset in the middle of both handshakes
        S_AXI_AWADDR = 8'h10; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 8'h10; S_AXI_ARVALID = 1'b1;
        n = 0;
        while (!S_AXI_AWREADY && n < 50) begin @(posedge ACLK); #1; n++; end
        if (!S_AXI_AWREADY) timeout("mid_awready");
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        check("mid_rst_ready", {S_AXI_AWREADY, S_AXI_ARREADY}, 0);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        check("mid_rst_valid", {S_AXI_BVALID, S_AXI_RVALID}, 0);
        check("mid_rst_outputs", {freq_o, gate_o, vel_o, update_o}, 0);
        do_read(8'h00, 32'h0, 2'b00);
        do_read(8'h04, 32'h0, 2'b00);
        do_read(8'h10, 32'h0, 2'b00);
        do_read(8'h40, 32'h0, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
